glitch_sequencer: RTL and testbench

GLITCH_SEQUENCER -- requirements
Module: glitch_sequencer

---
 rtl/glitch_pkg.sv | 15 +
 rtl/glitch_sequencer_if.sv | 32 +++
 rtl/trig_edge_det.sv | 23 ++
 rtl/glitch_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_glitch_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared types and default widths for the glitch sequencer
package glitch_pkg;

    localparam int CNT_W_DEF    = 32;
    localparam int NPULSE_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } glitch_state_t;

endpackage

// File: rtl/glitch_sequencer_if.sv
// rtl/glitch_sequencer_if.sv - configuration, trigger and status bundle of the glitch sequencer
interface glitch_sequencer_if #(
    parameter int CNT_W    = glitch_pkg::CNT_W_DEF,
    parameter int NPULSE_W = glitch_pkg::NPULSE_W_DEF
) ();

    logic                trig_in;
    logic                trig_pol;
    logic                arm;
    logic                abort;
    logic [CNT_W-1:0]    delay;
    logic [CNT_W-1:0]    width;
    logic [CNT_W-1:0]    gap;
    logic [NPULSE_W-1:0] count;
    logic [CNT_W-1:0]    timeout;
    logic                glitch_out;
    logic                armed;
    logic                busy;
    logic                done;
    logic                timed_out;

    modport master (
        output trig_in, trig_pol, arm, abort, delay, width, gap, count, timeout,
        input  glitch_out, armed, busy, done, timed_out
    );

    modport slave (
        input  trig_in, trig_pol, arm, abort, delay, width, gap, count, timeout,
        output glitch_out, armed, busy, done, timed_out
    );

endinterface

// File: rtl/trig_edge_det.sv
// rtl/trig_edge_det.sv - polarity-selectable trigger edge strobe
module trig_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic trig_in,
    input  logic pol,
    output logic edge_stb
);

    logic sample_q;

    // previous-cycle trigger sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= trig_in;
        end
    end

    assign edge_stb = pol ? (trig_in & ~sample_q) : (~trig_in & sample_q);

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - triggered glitch pulse train generator; GLITCH_SEQ_TIMEOUT_EN enables the armed-wait timeout
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int NPULSE_W = NPULSE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    glitch_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0]    CNT_ONE = CNT_W'(1);
    localparam logic [NPULSE_W-1:0] NP_ONE  = NPULSE_W'(1);

    glitch_state_t       state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NPULSE_W-1:0] npulse_q, npulse_d;
    logic [CNT_W-1:0]    delay_q, width_q, gap_q;
    logic                pol_q;
    logic                trig_edge;
    logic                cnt_last;
    logic                load_cfg;
    logic                glitch_out_q, glitch_out_d;
    logic                end_q, end_d;
    logic                done_q, done_d;
`ifdef GLITCH_SEQ_TIMEOUT_EN
    logic                timed_out_q, timed_out_d;
`else
    logic                unused_timeout;
    assign unused_timeout = ^bus.timeout;
`endif

    // zero-length phases still last one cycle
    function automatic logic [CNT_W-1:0] at_least_one(input logic [CNT_W-1:0] v);
        return (v == '0) ? CNT_ONE : v;
    endfunction

    trig_edge_det u_edge (
        .clk      (clk),
        .rst      (rst),
        .trig_in  (bus.trig_in),
        .pol      (pol_q),
        .edge_stb (trig_edge)
    );

    assign cnt_last = (cnt_q == CNT_ONE);
    assign load_cfg = (state_q == ST_IDLE) && bus.arm && !bus.abort;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state, phase counter and pulse counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        npulse_d = npulse_q;
        end_d    = 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
        timed_out_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (load_cfg) begin
                    state_d  = ST_ARMED;
                    npulse_d = (bus.count == '0) ? NP_ONE : bus.count;
`ifdef GLITCH_SEQ_TIMEOUT_EN
                    cnt_d    = bus.timeout;
`else
                    cnt_d    = '0;
`endif
                end
            end
            ST_ARMED: begin
                if (trig_edge) begin
                    if (delay_q == '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = at_least_one(width_q);
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = delay_q;
                    end
                end
`ifdef GLITCH_SEQ_TIMEOUT_EN
                // a zero timeout leaves the counter at 0, which never expires
                else if (cnt_last) begin
                    state_d     = ST_IDLE;
                    timed_out_d = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`endif
            end
            ST_DELAY: begin
                if (cnt_last) begin
                    state_d = ST_PULSE;
                    cnt_d   = at_least_one(width_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_PULSE: begin
                if (cnt_last) begin
                    if (npulse_q == NP_ONE) begin
                        state_d = ST_IDLE;
                        end_d   = 1'b1;
                    end else begin
                        state_d  = ST_GAP;
                        npulse_d = npulse_q - NP_ONE;
                        cnt_d    = at_least_one(gap_q);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_GAP: begin
                if (cnt_last) begin
                    state_d = ST_PULSE;
                    cnt_d   = at_least_one(width_q);
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.abort) begin
            state_d = ST_IDLE;
            end_d   = 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
            timed_out_d = 1'b0;
`endif
        end
    end

    // registered outputs trail the state by one cycle; abort silences them
    always_comb begin
        glitch_out_d = (state_q == ST_PULSE) && !bus.abort;
        done_d       = end_q && !bus.abort;
    end

    // datapath, latched configuration and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            npulse_q     <= '0;
            delay_q      <= '0;
            width_q      <= '0;
            gap_q        <= '0;
            pol_q        <= 1'b0;
            end_q        <= 1'b0;
            done_q       <= 1'b0;
            glitch_out_q <= 1'b0;
`ifdef GLITCH_SEQ_TIMEOUT_EN
            timed_out_q  <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            npulse_q     <= npulse_d;
            end_q        <= end_d;
            done_q       <= done_d;
            glitch_out_q <= glitch_out_d;
`ifdef GLITCH_SEQ_TIMEOUT_EN
            timed_out_q  <= timed_out_d;
`endif
            if (load_cfg) begin
                delay_q <= bus.delay;
                width_q <= bus.width;
                gap_q   <= bus.gap;
                pol_q   <= bus.trig_pol;
            end
        end
    end

    assign bus.glitch_out = glitch_out_q;
    assign bus.armed      = (state_q == ST_ARMED);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.done       = done_q;
`ifdef GLITCH_SEQ_TIMEOUT_EN
    assign bus.timed_out  = timed_out_q;
`else
    assign bus.timed_out  = 1'b0;
`endif

endmodule

// File: tb/tb_glitch_sequencer.sv
// tb/tb_glitch_sequencer.sv - directed self-checking bench for glitch_sequencer
module tb_glitch_sequencer;

    localparam int CNT_W    = 32;
    localparam int NPULSE_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    glitch_sequencer_if #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W)) bus ();

    glitch_sequencer #(.CNT_W(CNT_W), .NPULSE_W(NPULSE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic arm_cfg(input logic pol, input int dly, input int wid, input int gp,
                           input int cnt, input int tmo);
        bus.trig_in  = 1'b0;
        bus.trig_pol = pol;
        bus.delay    = CNT_W'(dly);
        bus.width    = CNT_W'(wid);
        bus.gap      = CNT_W'(gp);
        bus.count    = NPULSE_W'(cnt);
        bus.timeout  = CNT_W'(tmo);
        bus.arm      = 1'b1;
        step();
        bus.arm      = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.trig_in = 1'b0; bus.trig_pol = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0;
        bus.delay = '0; bus.width = '0; bus.gap = '0; bus.count = '0; bus.timeout = '0;
        step();
        step();
        check("rst_glitch", bus.glitch_out, 1'b0);
        check("rst_armed", bus.armed, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_timed_out", bus.timed_out, 1'b0);
        rst = 1'b0;

        // single pulse: delay 5, width 3
        arm_cfg(1'b1, 5, 3, 0, 1, 0);
        check("t1_armed", bus.armed, 1'b1);
        check("t1_busy", bus.busy, 1'b1);
        bus.trig_in = 1'b1;
        step();
        check("t1_armed_after_trig", bus.armed, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t1_glitch", bus.glitch_out, k >= 6 && k <= 8);
            check("t1_done", bus.done, k == 9);
        end
        check("t1_idle", bus.busy, 1'b0);

        // all-zero fields: one 1-cycle pulse right after the trigger
        arm_cfg(1'b1, 0, 0, 0, 0, 0);
        bus.trig_in = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t2_glitch", bus.glitch_out, k == 1);
            check("t2_done", bus.done, k == 2);
        end

        // falling-edge train: 3 pulses of 2, gaps of 4, delay 2
        arm_cfg(1'b0, 2, 2, 4, 3, 0);
        bus.trig_in = 1'b1;
        step();
        step();
        check("t3_rise_ignored_armed", bus.armed, 1'b1);
        check("t3_rise_ignored_glitch", bus.glitch_out, 1'b0);
        bus.trig_in = 1'b0;
        step();
        for (int k = 1; k <= 18; k++) begin
            int ph;
            step();
            ph = k - 3;
            check("t3_glitch", bus.glitch_out, ph >= 0 && ph < 17 && (ph % 6) < 2);
            check("t3_done", bus.done, k == 17);
        end

        // abort during the second pulse
        arm_cfg(1'b1, 1, 3, 2, 3, 0);
        bus.trig_in = 1'b1;
        step();
        for (int k = 1; k <= 7; k++) step();
        check("t4_second_pulse_high", bus.glitch_out, 1'b1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t4_abort_glitch", bus.glitch_out, 1'b0);
        check("t4_abort_busy", bus.busy, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t4_no_done", bus.done, 1'b0);
            check("t4_no_glitch", bus.glitch_out, 1'b0);
        end
        arm_cfg(1'b1, 0, 1, 0, 1, 0);
        check("t4_rearm", bus.armed, 1'b1);
        bus.trig_in = 1'b1;
        step();
        step();
        check("t4_rearm_glitch", bus.glitch_out, 1'b1);
        step();
        check("t4_rearm_done", bus.done, 1'b1);

        // armed-wait timeout, no trigger
        arm_cfg(1'b1, 3, 1, 0, 1, 10);
`ifdef GLITCH_SEQ_TIMEOUT_EN
        for (int k = 1; k <= 12; k++) begin
            step();
            check("t5_timed_out", bus.timed_out, k == 10);
            check("t5_armed", bus.armed, k < 10);
        end
`else
        for (int k = 1; k <= 15; k++) begin
            step();
            check("t5_armed_forever", bus.armed, 1'b1);
            check("t5_no_timeout", bus.timed_out, 1'b0);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("t5_abort_armed", bus.busy, 1'b0);
`endif

        // reset mid-DELAY clears outputs without a clock edge
        arm_cfg(1'b1, 20, 1, 0, 1, 0);
        bus.trig_in = 1'b1;
        step();
        step();
        step();
        check("t6_in_delay", bus.busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_busy", bus.busy, 1'b0);
        check("t6_rst_armed", bus.armed, 1'b0);
        check("t6_rst_glitch", bus.glitch_out, 1'b0);
        check("t6_rst_done", bus.done, 1'b0);
        step();
        rst = 1'b0;

        // reset mid-pulse drops glitch_out immediately
        arm_cfg(1'b1, 0, 10, 0, 1, 0);
        bus.trig_in = 1'b1;
        step();
        step();
        step();
        check("t7_pulse_high", bus.glitch_out, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("t7_rst_glitch", bus.glitch_out, 1'b0);
        step();
        rst = 1'b0;

        // arm and abort together: abort wins
        bus.trig_in = 1'b0;
        bus.delay = CNT_W'(2); bus.width = CNT_W'(1); bus.count = NPULSE_W'(1);
        bus.arm = 1'b1;
        bus.abort = 1'b1;
        step();
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        check("t8_busy", bus.busy, 1'b0);
        check("t8_armed", bus.armed, 1'b0);
        step();
        check("t8_busy_later", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
